uart_mmio_initiator: RTL and testbench

UART_MMIO_INITIATOR -- requirements
Module: uart_mmio_initiator

---
 rtl/uart_mmio_initiator.sv | 165 ++++++++++++++++
 tb/tb_uart_mmio_initiator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_initiator.sv
// Turns single commands into polled UART / MMIO accesses and returns one response each.
// Latency: op-dependent (1..5 cycles, plus 2 per failed CTRL poll); busy commands wait, response held until rsp_ready.
module uart_mmio_initiator #(
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mm_en,
    output logic [15:0] mm_addr,
    output logic [31:0] mm_wdata,
    output logic [7:0]  mm_tx_byte,
    output logic        mm_tx_valid,
    output logic        mm_rx_ready,
    input  logic [31:0] mm_rdata
);
    localparam int CW = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] OP_GETC    = 3'd0;
    localparam logic [2:0] OP_PUTC    = 3'd1;
    localparam logic [2:0] OP_RD_CC   = 3'd2;
    localparam logic [2:0] OP_RD_IC   = 3'd3;
    localparam logic [2:0] OP_RST_CTR = 3'd4;
    localparam logic [2:0] OP_RD_SW   = 3'd5;
    localparam logic [2:0] OP_WR_LED  = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam logic [15:0] A_CTRL = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_CHECK, S_ACCESS, S_CAPTURE, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    logic [15:0]    op_addr;
    logic [CW-1:0]  cnt_inc;
    logic           poll_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        op_addr = 16'h0000;
        case (op_q)
            OP_GETC:    op_addr = 16'h0004;
            OP_PUTC:    op_addr = 16'h0008;
            OP_RD_CC:   op_addr = 16'h0010;
            OP_RD_IC:   op_addr = 16'h0014;
            OP_RST_CTR: op_addr = 16'h0018;
            OP_RD_SW:   op_addr = 16'h0028;
            OP_WR_LED:  op_addr = 16'h0030;
            default:    op_addr = 16'h0000;
        endcase
    end

    assign cnt_inc = cnt_q + CW'(1);
    // GETC waits for rx-valid (bit1), PUTC for tx-ready (bit0).
    assign poll_ok = (op_q == OP_GETC) ? mm_rdata[1] : mm_rdata[0];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mm_en       = 1'b0;
        mm_addr     = 16'h0000;
        mm_wdata    = 32'h0;
        mm_tx_byte  = 8'h00;
        mm_tx_valid = 1'b0;
        mm_rx_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = rst;
                if (cmd_valid && rst) begin
                    op_d       = cmd_op;
                    wdata_d    = cmd_wdata;
                    cnt_d      = '0;
                    rsp_data_d = 32'h0;
                    rsp_err_d  = (cmd_op == OP_ILLEGAL);
                    if (cmd_op == OP_GETC || cmd_op == OP_PUTC) state_d = S_POLL;
                    else if (cmd_op == OP_ILLEGAL)              state_d = S_RESP;
                    else                                        state_d = S_ACCESS;
                end
            end
            S_POLL: begin
                mm_en   = 1'b1;
                mm_addr = A_CTRL;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (poll_ok) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(POLL_LIMIT)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'h0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_POLL;
                    end
                end
            end
            S_ACCESS: begin
                mm_en   = 1'b1;
                mm_addr = op_addr;
                if (op_q == OP_PUTC) begin
                    mm_tx_valid = 1'b1;
                    mm_tx_byte  = wdata_q[7:0];
                end
                if (op_q == OP_GETC)   mm_rx_ready = 1'b1;
                if (op_q == OP_WR_LED) mm_wdata    = wdata_q;
                if (op_q == OP_PUTC || op_q == OP_RST_CTR || op_q == OP_WR_LED) state_d = S_RESP;
                else                                                             state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                case (op_q)
                    OP_GETC:  rsp_data_d = {24'h0, mm_rdata[7:0]};
                    OP_RD_SW: rsp_data_d = {30'h0, mm_rdata[1:0]};
                    default:  rsp_data_d = mm_rdata;
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_uart_mmio_initiator.sv
// Directed bench for uart_mmio_initiator with a registered MMIO/UART responder model.
module tb_uart_mmio_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mm_en;
    logic [15:0] mm_addr;
    logic [31:0] mm_wdata;
    logic [7:0]  mm_tx_byte;
    logic        mm_tx_valid, mm_rx_ready;
    logic [31:0] mm_rdata;

    uart_mmio_initiator #(.POLL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mm_en(mm_en), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_tx_byte(mm_tx_byte),
        .mm_tx_valid(mm_tx_valid), .mm_rx_ready(mm_rx_ready), .mm_rdata(mm_rdata)
    );

    always #5 clk = ~clk;

    // Responder configuration, written only by the stimulus process.
    int          poll_base = 0;
    int          ctrl_fail = 0;
    logic [31:0] ctrl_ok   = 32'h3;
    logic [31:0] cc_val = 32'h0, ic_val = 32'h0, sw_val = 32'h0, rx_val = 32'h0;

    // Event totals, written only by the responder process.
    int          n_polls = 0, n_en = 0, n_tx = 0, n_rx = 0;
    logic [15:0] last_addr = 16'h0, tx_addr = 16'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [7:0]  tx_byte = 8'h0;

    initial mm_rdata = 32'h0;

    always @(posedge clk) begin
        if (mm_en) begin
            n_en <= n_en + 1;
            if (mm_addr == 16'h0000) begin
                mm_rdata <= ((n_polls - poll_base) < ctrl_fail) ? 32'h0 : ctrl_ok;
                n_polls  <= n_polls + 1;
            end else begin
                last_addr  <= mm_addr;
                last_wdata <= mm_wdata;
                case (mm_addr)
                    16'h0004: mm_rdata <= rx_val;
                    16'h0010: mm_rdata <= cc_val;
                    16'h0014: mm_rdata <= ic_val;
                    16'h0028: mm_rdata <= sw_val;
                    default:  mm_rdata <= 32'hDEAD_BEEF;
                endcase
            end
        end
        if (mm_tx_valid) begin
            n_tx    <= n_tx + 1;
            tx_byte <= mm_tx_byte;
            tx_addr <= mm_addr;
        end
        if (mm_rx_ready) n_rx <= n_rx + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command; lat = cycle index (1 = first cycle after accept) where rsp_valid is seen.
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] wd, output int lat);
        @(negedge clk);
        check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = 99;
    endtask

    task automatic pop_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    int lat;
    int s_polls, s_en, s_tx, s_rx;

    task automatic snap();
        s_polls = n_polls; s_en = n_en; s_tx = n_tx; s_rx = n_rx;
        poll_base = n_polls;
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mm_en",     {31'h0, mm_en},     32'h0);
        check("rst_rsp_data",  rsp_data,           32'h0);
        check("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("release_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // RD_CC
        cc_val = 32'h0000_1234; snap();
        run_cmd(3'd2, 32'h0, lat);
        check("rdcc_lat",  lat, 3);
        check("rdcc_data", rsp_data, 32'h0000_1234);
        check("rdcc_err",  {31'h0, rsp_err}, 32'h0);
        check("rdcc_addr", {16'h0, last_addr}, 32'h0010);
        check("rdcc_polls", n_polls - s_polls, 0);
        pop_rsp();

        // PUTC with two failed polls
        ctrl_fail = 2; ctrl_ok = 32'h1; snap();
        run_cmd(3'd1, 32'h0000_0041, lat);
        check("putc_lat",    lat, 8);
        check("putc_polls",  n_polls - s_polls, 3);
        check("putc_en",     n_en - s_en, 4);
        check("putc_tx_cnt", n_tx - s_tx, 1);
        check("putc_tx_byte", {24'h0, tx_byte}, 32'h41);
        check("putc_tx_addr", {16'h0, tx_addr}, 32'h0008);
        check("putc_data",   rsp_data, 32'h0);
        check("putc_err",    {31'h0, rsp_err}, 32'h0);
        pop_rsp();

        // GETC timeout: CTRL never ready
        ctrl_fail = 1000; snap();
        run_cmd(3'd0, 32'h0, lat);
        check("getc_to_lat",   lat, 9);
        check("getc_to_polls", n_polls - s_polls, 4);
        check("getc_to_rx",    n_rx - s_rx, 0);
        check("getc_to_en",    n_en - s_en, 4);
        check("getc_to_err",   {31'h0, rsp_err}, 32'h1);
        check("getc_to_data",  rsp_data, 32'h0);
        pop_rsp();

        // GETC success, data masked to a byte
        ctrl_fail = 0; ctrl_ok = 32'h2; rx_val = 32'h0000_01CB; snap();
        run_cmd(3'd0, 32'h0, lat);
        check("getc_lat",  lat, 5);
        check("getc_data", rsp_data, 32'h0000_00CB);
        check("getc_rx",   n_rx - s_rx, 1);
        check("getc_err",  {31'h0, rsp_err}, 32'h0);
        pop_rsp();

        // RD_SW masked to two bits
        sw_val = 32'hFFFF_FFFE; snap();
        run_cmd(3'd5, 32'h0, lat);
        check("rdsw_lat",  lat, 3);
        check("rdsw_data", rsp_data, 32'h2);
        check("rdsw_addr", {16'h0, last_addr}, 32'h0028);
        pop_rsp();

        // RD_IC
        ic_val = 32'hCAFE_0001; snap();
        run_cmd(3'd3, 32'h0, lat);
        check("rdic_lat",  lat, 3);
        check("rdic_data", rsp_data, 32'hCAFE_0001);
        pop_rsp();

        // WR_LED with response held off
        snap();
        run_cmd(3'd6, 32'h0000_002A, lat);
        check("led_lat",   lat, 2);
        check("led_addr",  {16'h0, last_addr}, 32'h0030);
        check("led_wdata", last_wdata, 32'h2A);
        check("led_data",  rsp_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("led_hold_valid", {31'h0, rsp_valid}, 32'h1);
            check("led_hold_ready", {31'h0, cmd_ready}, 32'h0);
            check("led_hold_data",  rsp_data, 32'h0);
        end
        pop_rsp();
        @(negedge clk);
        check("led_after_ready", {31'h0, cmd_ready}, 32'h1);
        check("led_after_valid", {31'h0, rsp_valid}, 32'h0);

        // RST_CTR
        snap();
        run_cmd(3'd4, 32'h0, lat);
        check("rstctr_lat",  lat, 2);
        check("rstctr_addr", {16'h0, last_addr}, 32'h0018);
        pop_rsp();

        // Illegal op
        snap();
        run_cmd(3'd7, 32'h0, lat);
        check("ill_lat",  lat, 1);
        check("ill_err",  {31'h0, rsp_err}, 32'h1);
        check("ill_data", rsp_data, 32'h0);
        check("ill_en",   n_en - s_en, 0);
        pop_rsp();

        // Reset during CHECK of GETC
        ctrl_fail = 1000; snap();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_wdata = 32'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_poll_en", {31'h0, mm_en}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("abort_mm_en",     {31'h0, mm_en}, 32'h0);
        check("abort_addr",      {16'h0, mm_addr}, 32'h0);
        check("abort_err",       {31'h0, rsp_err}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_release_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (6) begin
            @(negedge clk);
            check("abort_idle_valid", {31'h0, rsp_valid}, 32'h0);
        end
        check("abort_polls", n_polls - s_polls, 1);
        check("abort_rx",    n_rx - s_rx, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
